data_memory_ls: RTL and testbench

Parametrised successor to the single-word data memory for the RISC-V datapath. Byte-addressable, word-organised RAM that takes RISC-V load/store sizes (byte/half/word, signed/unsigned) from funct3 and writes individual byte lanes. Read data is registered with a valid pulse, and misaligned or illegal accesses raise a fault. After reset, a hardware clear sequencer zeroes the whole array before the first request is accepted. Sits between the ALU result/rs2 path and the writeback mux.

---
 rtl/data_memory_ls.sv | 161 ++++++++++++++++
 tb/tb_data_memory_ls.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/data_memory_ls.sv
// Byte-addressable word RAM with RISC-V load/store sizing, byte-lane writes and fault detection.
// Latency: stores commit at the accept edge; load data and RD_Valid/Fault pulses appear one cycle after accept.
// Backpressure: Ready=0 during the post-reset clear sweep (build option DMEM_CLEAR_EN); Req is ignored, never queued.
module data_memory_ls #(
  parameter  int DEPTH_WORDS = 64,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req,
  output logic        Ready,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Address,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        RD_Valid,
  output logic        Fault
);

`ifdef DMEM_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
  logic [IDX_W-1:0] clr_ptr;
`else
  typedef enum logic {ST_BOOT, ST_IDLE} state_t;
`endif

  state_t state;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             accept;
  logic             bad;
  logic             store_we;
  logic [3:0]       be;
  logic [31:0]      wdat;
  logic [31:0]      rword;
  logic [7:0]       rbyte;
  logic [15:0]      rhalf;
  logic [31:0]      ldat;

  // Address bits above the word index alias onto the array.
  logic unused_addr;
  assign unused_addr = ^Address[31:IDX_W+2];

  assign idx      = Address[IDX_W+1:2];
  assign accept   = Req && Ready;
  assign store_we = accept && MemWrite && !bad;

  // Reject illegal funct3 codes and misaligned half/word accesses.
  always_comb begin
    bad = 1'b0;
    if (MemWrite) begin
      case (Funct3)
        3'b000:  bad = 1'b0;
        3'b001:  bad = Address[0];
        3'b010:  bad = |Address[1:0];
        default: bad = 1'b1;
      endcase
    end else begin
      case (Funct3)
        3'b000, 3'b100: bad = 1'b0;
        3'b001, 3'b101: bad = Address[0];
        3'b010:         bad = |Address[1:0];
        default:        bad = 1'b1;
      endcase
    end
  end

  // Replicate store data across lanes and pick the byte enables for the access size.
  always_comb begin
    be   = 4'b0000;
    wdat = WD;
    case (Funct3[1:0])
      2'b00: begin
        be[Address[1:0]] = 1'b1;
        wdat             = {4{WD[7:0]}};
      end
      2'b01: begin
        be   = Address[1] ? 4'b1100 : 4'b0011;
        wdat = {2{WD[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // Select the addressed byte/half from the word and extend it for the load type.
  always_comb begin
    rword = mem[idx];
    case (Address[1:0])
      2'b00:   rbyte = rword[7:0];
      2'b01:   rbyte = rword[15:8];
      2'b10:   rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = Address[1] ? rword[31:16] : rword[15:0];
    case (Funct3)
      3'b000:  ldat = {{24{rbyte[7]}}, rbyte};
      3'b001:  ldat = {{16{rhalf[15]}}, rhalf};
      3'b100:  ldat = {24'h0, rbyte};
      3'b101:  ldat = {16'h0, rhalf};
      default: ldat = rword;
    endcase
  end

  // Array write port: the clear sweep owns it until IDLE, then lane-masked stores.
  // The array itself is not reset; while held in reset the sweep just rewrites word 0 with zero.
  always_ff @(posedge CLK) begin
`ifdef DMEM_CLEAR_EN
    if (state == ST_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else
`endif
    if (store_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
`ifdef DMEM_CLEAR_EN
      state    <= ST_CLEAR;
      clr_ptr  <= '0;
`else
      state    <= ST_BOOT;
`endif
      Ready    <= 1'b0;
      RD       <= '0;
      RD_Valid <= 1'b0;
      Fault    <= 1'b0;
    end else begin
      case (state)
`ifdef DMEM_CLEAR_EN
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + IDX_W'(1);
          if (clr_ptr == IDX_W'(DEPTH_WORDS - 1)) begin
            state <= ST_IDLE;
            Ready <= 1'b1;
          end
        end
`else
        ST_BOOT: begin
          state <= ST_IDLE;
          Ready <= 1'b1;
        end
`endif
        default: begin
          state <= ST_IDLE;
          Ready <= 1'b1;
        end
      endcase
      RD_Valid <= accept && !MemWrite && !bad;
      Fault    <= accept && bad;
      if (accept && !MemWrite && !bad) RD <= ldat;
    end
  end

endmodule

// File: tb/tb_data_memory_ls.sv
// Directed self-checking bench for data_memory_ls (DEPTH_WORDS=64).
// Inputs are driven and outputs sampled on the falling clock edge.
// Clear-specific expectations follow the DMEM_CLEAR_EN build option.
module tb_data_memory_ls;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Req = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] Address = '0;
  logic [31:0] WD = '0;
  logic        Ready;
  logic [31:0] RD;
  logic        RD_Valid;
  logic        Fault;

  int checks   = 0;
  int failures = 0;
  int n;

  data_memory_ls #(.DEPTH_WORDS(64)) dut (
    .CLK(CLK), .RST(RST), .Req(Req), .Ready(Ready), .MemWrite(MemWrite),
    .Funct3(Funct3), .Address(Address), .WD(WD), .RD(RD),
    .RD_Valid(RD_Valid), .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One accepted request; returns at the next falling edge where its result is visible.
  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    Req = 1'b1; MemWrite = we; Funct3 = f3; Address = a; WD = d;
    @(negedge CLK);
    Req = 1'b0;
  endtask

  // Counts falling-edge samples with Ready low, starting at the current one.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!Ready && cnt < 500) begin
      cnt++;
      @(negedge CLK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge CLK);
    chk("rst_ready", {31'h0, Ready}, 32'h0);
    chk("rst_rd", RD, 32'h0);
    chk("rst_vld_flt", {30'h0, RD_Valid, Fault}, 32'h0);
    RST = 1'b1;
    wait_ready(n);
`ifdef DMEM_CLEAR_EN
    chk("clear_len", n, 64);
    op(1'b0, 3'b010, 32'hFFE8, 32'h0);
    chk("clr_lw_rd", RD, 32'h0);
    chk("clr_lw_vld", {31'h0, RD_Valid}, 32'h1);
`else
    chk("boot_len", n, 1);
`endif

    // Word store/load, back-to-back loads
    op(1'b1, 3'b010, 32'hFFE8, 32'd14);
    chk("sw_no_vld_flt", {30'h0, RD_Valid, Fault}, 32'h0);
    op(1'b1, 3'b010, 32'hFFE4, 32'd7);
    op(1'b0, 3'b010, 32'hFFE8, 32'h0);
    chk("lw1_rd", RD, 32'd14);
    chk("lw1_vld", {31'h0, RD_Valid}, 32'h1);
    op(1'b0, 3'b010, 32'hFFE4, 32'h0);
    chk("lw2_rd", RD, 32'd7);
    chk("lw2_vld_flt", {30'h0, RD_Valid, Fault}, 32'h2);
    @(negedge CLK);
    chk("vld_drop", {31'h0, RD_Valid}, 32'h0);
    chk("rd_hold", RD, 32'd7);

    // Byte lanes and extension
    op(1'b1, 3'b010, 32'h10, 32'h11223344);
    op(1'b1, 3'b000, 32'h11, 32'h000000AA);
    op(1'b0, 3'b010, 32'h10, 32'h0);
    chk("sb_lane", RD, 32'h1122AA44);
    op(1'b0, 3'b000, 32'h11, 32'h0);
    chk("lb_sext", RD, 32'hFFFFFFAA);
    op(1'b0, 3'b100, 32'h11, 32'h0);
    chk("lbu_zext", RD, 32'h000000AA);
    op(1'b0, 3'b001, 32'h12, 32'h0);
    chk("lh_pos", RD, 32'h00001122);
    op(1'b1, 3'b001, 32'h12, 32'h00008001);
    op(1'b0, 3'b001, 32'h12, 32'h0);
    chk("lh_neg", RD, 32'hFFFF8001);
    op(1'b0, 3'b101, 32'h12, 32'h0);
    chk("lhu_zext", RD, 32'h00008001);

    // Faults
    op(1'b1, 3'b001, 32'h13, 32'h0000BEEF);
    chk("sh_mis_flt_vld", {30'h0, RD_Valid, Fault}, 32'h1);
    op(1'b0, 3'b010, 32'h10, 32'h0);
    chk("sh_mis_nowrite", RD, 32'h8001AA44);
    chk("flt_drop", {31'h0, Fault}, 32'h0);
    op(1'b0, 3'b010, 32'h22, 32'h0);
    chk("lw_mis_flt_vld", {30'h0, RD_Valid, Fault}, 32'h1);
    chk("lw_mis_rd_hold", RD, 32'h8001AA44);
    op(1'b0, 3'b011, 32'h10, 32'h0);
    chk("ld_f3_011", {30'h0, RD_Valid, Fault}, 32'h1);
    op(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
    chk("st_f3_100", {30'h0, RD_Valid, Fault}, 32'h1);
    op(1'b0, 3'b010, 32'h10, 32'h0);
    chk("st_bad_nowrite", RD, 32'h8001AA44);

    // Aliasing
    op(1'b1, 3'b010, 32'h0, 32'h5);
    op(1'b0, 3'b010, 32'h100, 32'h0);
    chk("alias", RD, 32'h5);

    // Reset right after a load accept discards it
    op(1'b1, 3'b010, 32'h40, 32'h5);
    Req = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Address = 32'h40;
    @(posedge CLK);
    #1 RST = 1'b0;
    Req = 1'b0;
    @(negedge CLK);
    chk("mid_rst_vld", {31'h0, RD_Valid}, 32'h0);
    chk("mid_rst_rd", RD, 32'h0);
    chk("mid_rst_ready", {31'h0, Ready}, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
`ifdef DMEM_CLEAR_EN
    Req = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Address = 32'h40;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("clr_req_ignored", {31'h0, RD_Valid}, 32'h0);
    end
    Req = 1'b0;
    wait_ready(n);
    chk("reclear_done", {31'h0, Ready}, 32'h1);
    op(1'b0, 3'b010, 32'h40, 32'h0);
    chk("reclear_rd", RD, 32'h0);
`else
    wait_ready(n);
    chk("reboot_len", n, 1);
    op(1'b0, 3'b010, 32'h40, 32'h0);
    chk("retain_rd", RD, 32'h5);
`endif
    chk("post_rst_vld", {31'h0, RD_Valid}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
